// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF/MEM requester, RAM pin and run-enable bundle.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        busy;

  modport slave (
    input  rdy_in,
    input  if_req,
    input  if_addr,
    input  if_flush,
    output if_done,
    output if_data,
    input  mem_req,
    input  mem_we,
    input  mem_size,
    input  mem_addr,
    input  mem_wdata,
    output mem_done,
    output mem_rdata,
    output ram_a,
    output ram_dout,
    output ram_wr,
    input  ram_din,
    output busy
  );

  modport master (
    output rdy_in,
    output if_req,
    output if_addr,
    output if_flush,
    input  if_done,
    input  if_data,
    output mem_req,
    output mem_we,
    output mem_size,
    output mem_addr,
    output mem_wdata,
    input  mem_done,
    input  mem_rdata,
    input  ram_a,
    input  ram_dout,
    input  ram_wr,
    output ram_din,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-wide RAM/IO port shared by fetch and load/store.
// Macro ARB_FAIRNESS_EN adds a starvation bound for fetch.
module mem_arbiter
`ifdef ARB_FAIRNESS_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state;
  logic        r_own_if;
  logic        w_own_if;
  logic [2:0]  r_n;
  logic [2:0]  w_n;
  logic [31:0] r_addr;
  logic [31:0] w_addr;
  logic [31:0] r_wdata;
  logic [31:0] w_wdata;
  logic [2:0]  r_beat;
  logic [2:0]  w_beat;
  logic [31:0] r_data;
  logic [31:0] w_data;
  logic        r_flush;
  logic        w_flush;
  logic [31:0] r_ram_a;
  logic [31:0] w_ram_a;
  logic [7:0]  r_ram_dout;
  logic [7:0]  w_ram_dout;
  logic        r_ram_wr;
  logic        w_ram_wr;
  logic        r_if_done;
  logic        w_if_done;
  logic [31:0] r_if_data;
  logic [31:0] w_if_data;
  logic        r_mem_done;
  logic        w_mem_done;
  logic [31:0] r_mem_rdata;
  logic [31:0] w_mem_rdata;
  logic        r_busy;
  logic [2:0]  w_mem_n;
  logic [2:0]  w_nxt;
  logic [1:0]  w_cidx;
  logic        w_force;
  logic        w_grant_if;
  logic        w_grant_mem;

`ifdef ARB_FAIRNESS_EN
  logic [7:0]  r_starve;

  assign w_force = 32'(r_starve) >= 32'(STARVE_LIMIT);

  // count MEM wins that leave a fetch waiting; an IF win clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= 8'd0;
    end else if (io_bus.rdy_in && r_state == S_IDLE) begin
      if (w_grant_if) begin
        r_starve <= 8'd0;
      end else if (w_grant_mem && io_bus.if_req) begin
        if (r_starve != 8'hFF) r_starve <= r_starve + 8'd1;
      end
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_grant_if  = io_bus.if_req && !io_bus.if_flush &&
                       (!io_bus.mem_req || w_force);
  assign w_grant_mem = io_bus.mem_req && !w_grant_if;
  assign w_nxt       = r_beat + 3'd1;
  assign w_cidx      = r_beat[1:0] - 2'd1;

  // beat count for a MEM request; IO loads are a single byte
  always_comb begin
    w_mem_n = 3'd1;
    unique case (io_bus.mem_size)
      2'b10:   w_mem_n = 3'd2;
      2'b11:   w_mem_n = 3'd4;
      default: w_mem_n = 3'd1;
    endcase
    if (!io_bus.mem_we && io_bus.mem_addr[17:16] == 2'b11)
      w_mem_n = 3'd1;
  end

  // next state and next values of every registered output
  always_comb begin
    w_state     = r_state;
    w_own_if    = r_own_if;
    w_n         = r_n;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_beat      = r_beat;
    w_data      = r_data;
    w_flush     = r_flush;
    w_ram_a     = r_ram_a;
    w_ram_dout  = r_ram_dout;
    w_ram_wr    = r_ram_wr;
    w_if_done   = 1'b0;
    w_if_data   = 32'd0;
    w_mem_done  = 1'b0;
    w_mem_rdata = 32'd0;
    unique case (r_state)
      S_IDLE: begin
        w_beat  = 3'd0;
        w_data  = 32'd0;
        w_flush = 1'b0;
        if (w_grant_if) begin
          w_own_if = 1'b1;
          w_n      = 3'd4;
          w_addr   = io_bus.if_addr;
          w_ram_a  = io_bus.if_addr;
          w_state  = S_RD;
        end else if (w_grant_mem) begin
          w_own_if = 1'b0;
          w_n      = w_mem_n;
          w_addr   = io_bus.mem_addr;
          w_wdata  = io_bus.mem_wdata;
          w_ram_a  = io_bus.mem_addr;
          if (io_bus.mem_we) begin
            w_ram_wr   = 1'b1;
            w_ram_dout = io_bus.mem_wdata[7:0];
            w_state    = S_WR;
          end else begin
            w_state = S_RD;
          end
        end
      end
      S_RD: begin
        if (r_own_if && io_bus.if_flush) w_flush = 1'b1;
        if (r_beat != 3'd0)
          w_data[{w_cidx, 3'b000} +: 8] = io_bus.ram_din;
        if (w_nxt < r_n)
          w_ram_a = r_addr + {29'd0, w_nxt};
        if (r_beat == r_n) begin
          w_state = S_DONE;
          if (r_own_if) begin
            if (!w_flush) begin
              w_if_done = 1'b1;
              w_if_data = w_data;
            end
          end else begin
            w_mem_done  = 1'b1;
            w_mem_rdata = w_data;
          end
        end else begin
          w_beat = w_nxt;
        end
      end
      S_WR: begin
        if (w_nxt < r_n) begin
          w_ram_a    = r_addr + {29'd0, w_nxt};
          w_ram_dout = r_wdata[{w_nxt[1:0], 3'b000} +: 8];
          w_beat     = w_nxt;
        end else begin
          w_ram_wr   = 1'b0;
          w_mem_done = 1'b1;
          w_state    = S_DONE;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // state register; rdy_in low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (io_bus.rdy_in) begin
      r_state <= w_state;
    end
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_own_if    <= 1'b0;
      r_n         <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_beat      <= 3'd0;
      r_data      <= 32'd0;
      r_flush     <= 1'b0;
      r_ram_a     <= 32'd0;
      r_ram_dout  <= 8'd0;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_done  <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_busy      <= 1'b0;
    end else if (io_bus.rdy_in) begin
      r_own_if    <= w_own_if;
      r_n         <= w_n;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_beat      <= w_beat;
      r_data      <= w_data;
      r_flush     <= w_flush;
      r_ram_a     <= w_ram_a;
      r_ram_dout  <= w_ram_dout;
      r_ram_wr    <= w_ram_wr;
      r_if_done   <= w_if_done;
      r_if_data   <= w_if_data;
      r_mem_done  <= w_mem_done;
      r_mem_rdata <= w_mem_rdata;
      r_busy      <= (w_state != S_IDLE);
    end
  end

  assign io_bus.ram_a     = r_ram_a;
  assign io_bus.ram_dout  = r_ram_dout;
  assign io_bus.ram_wr    = r_ram_wr & io_bus.rdy_in;
  assign io_bus.if_done   = r_if_done;
  assign io_bus.if_data   = r_if_data;
  assign io_bus.mem_done  = r_mem_done;
  assign io_bus.mem_rdata = r_mem_rdata;
  assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks with queued expectations
// against a synchronous byte RAM model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0]  ram [0:4095];
  wr_t         q_obs[$];
  wr_t         q_exp[$];
  logic [31:0] q_if[$];
  logic [31:0] q_mem[$];
  int          checks = 0;
  int          errors = 0;

  // byte RAM: one-cycle read latency, frozen while rdy_in is low
  always @(posedge clk) begin
    if (bus.rdy_in) begin
      bus.ram_din <= ram[bus.ram_a[11:0]];
      if (bus.ram_wr) begin
        ram[bus.ram_a[11:0]] = bus.ram_dout;
        q_obs.push_back({bus.ram_a, bus.ram_dout});
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.ram_a !== 32'd0) begin
      errors++;
      $display("FAIL rst_ram_a got %h want 0", bus.ram_a);
    end
    checks++;
    if (bus.ram_wr !== 1'b0) begin
      errors++;
      $display("FAIL rst_ram_wr got %b want 0", bus.ram_wr);
    end
    checks++;
    if (bus.ram_dout !== 8'd0) begin
      errors++;
      $display("FAIL rst_dout got %h want 0", bus.ram_dout);
    end
    checks++;
    if (bus.if_done !== 1'b0 || bus.if_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_if got %b/%h want 0/0",
               bus.if_done, bus.if_data);
    end
    checks++;
    if (bus.mem_done !== 1'b0 || bus.mem_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_mem got %b/%h want 0/0",
               bus.mem_done, bus.mem_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_if_fetch();
    logic [31:0] got;
    logic [31:0] exp;
    int lat;
    bit seen;
    ram[12'h100] = 8'h13;
    ram[12'h101] = 8'h00;
    ram[12'h102] = 8'h50;
    ram[12'h103] = 8'h00;
    q_if.push_back(32'h0050_0013);
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    seen = 1'b0;
    lat  = 0;
    got  = 32'd0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        checks++;
        if (bus.ram_a !== 32'h100 + 32'(c - 1)) begin
          errors++;
          $display("FAIL fetch_addr%0d got %h want %h",
                   c, bus.ram_a, 32'h100 + 32'(c - 1));
        end
      end
      if (bus.if_done) begin
        seen = 1'b1;
        lat  = c;
        got  = bus.if_data;
        bus.if_req = 1'b0;
      end
    end
    bus.if_req = 1'b0;
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL fetch_lat got %0d want 6", lat);
    end
    exp = q_if.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL fetch_data got %h want %h", got, exp);
    end
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b0 || bus.if_data !== 32'd0) begin
      errors++;
      $display("FAIL fetch_clear got %b/%h want 0/0",
               bus.if_done, bus.if_data);
    end
  endtask

  task automatic test_priority();
    logic [31:0] md;
    logic [31:0] id;
    logic [31:0] exp;
    int mc;
    int ic;
    ram[12'h200] = 8'h78;
    ram[12'h201] = 8'h56;
    ram[12'h202] = 8'h34;
    ram[12'h203] = 8'h12;
    q_mem.push_back(32'h1234_5678);
    q_if.push_back(32'h0050_0013);
    @(negedge clk);
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h100;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_size  = 2'b11;
    bus.mem_addr  = 32'h200;
    mc = 0;
    ic = 0;
    md = 32'd0;
    id = 32'd0;
    for (int c = 1; c <= 30 && ic == 0; c++) begin
      @(negedge clk);
      if (mc != 0 && c == mc + 1) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL prio_idle_busy got %b want 0", bus.busy);
        end
        bus.mem_req = 1'b0;
      end
      if (bus.mem_done) begin
        mc = c;
        md = bus.mem_rdata;
      end
      if (bus.if_done) begin
        ic = c;
        id = bus.if_data;
        bus.if_req = 1'b0;
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    checks++;
    if (mc != 6 || ic != 13) begin
      errors++;
      $display("FAIL prio_order got mem@%0d if@%0d want 6/13", mc, ic);
    end
    exp = q_mem.pop_front();
    checks++;
    if (md !== exp) begin
      errors++;
      $display("FAIL prio_mdata got %h want %h", md, exp);
    end
    exp = q_if.pop_front();
    checks++;
    if (id !== exp) begin
      errors++;
      $display("FAIL prio_idata got %h want %h", id, exp);
    end
  endtask

  task automatic test_store_half();
    wr_t o;
    wr_t e;
    logic [31:0] rd;
    int lat;
    int wcnt;
    @(negedge clk);
    q_obs.delete();
    q_exp.push_back({32'h31, 8'hEF});
    q_exp.push_back({32'h32, 8'hBE});
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_size  = 2'b10;
    bus.mem_addr  = 32'h31;
    bus.mem_wdata = 32'h0000_BEEF;
    lat  = 0;
    wcnt = 0;
    rd   = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.ram_wr) wcnt++;
      if (bus.mem_done) begin
        lat = c;
        rd  = bus.mem_rdata;
        bus.mem_req = 1'b0;
      end
    end
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    checks++;
    if (lat != 3 || wcnt != 2) begin
      errors++;
      $display("FAIL sh_timing got lat %0d wr %0d want 3/2", lat, wcnt);
    end
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL sh_rdata got %h want 0", rd);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_obs.size() == 0) begin
        errors++;
        $display("FAIL sh_write got none want %h/%h", e.a, e.d);
      end else begin
        o = q_obs.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL sh_write got %h/%h want %h/%h",
                   o.a, o.d, e.a, e.d);
        end
      end
    end
    checks++;
    if (q_obs.size() != 0) begin
      errors++;
      $display("FAIL sh_extra got %0d want 0", q_obs.size());
    end
  endtask

  task automatic test_io_load();
    logic [31:0] got;
    logic [31:0] exp;
    int lat;
    ram[12'h000] = 8'h41;
    ram[12'h001] = 8'h99;
    ram[12'h002] = 8'h99;
    ram[12'h003] = 8'h99;
    q_mem.push_back(32'h0000_0041);
    @(negedge clk);
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_size = 2'b11;
    bus.mem_addr = 32'h0003_0000;
    lat = 0;
    got = 32'd0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (bus.ram_a !== 32'h0003_0000) begin
          errors++;
          $display("FAIL io_addr got %h want 30000", bus.ram_a);
        end
      end
      if (bus.mem_done) begin
        lat = c;
        got = bus.mem_rdata;
        bus.mem_req = 1'b0;
      end
    end
    bus.mem_req = 1'b0;
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL io_lat got %0d want 3", lat);
    end
    exp = q_mem.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL io_data got %h want %h", got, exp);
    end
  endtask

  task automatic test_flush();
    int dcnt;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    dcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.if_done) dcnt++;
      if (c == 4) begin
        checks++;
        if (bus.ram_a !== 32'h103) begin
          errors++;
          $display("FAIL flush_beat4 got %h want 103", bus.ram_a);
        end
        bus.if_flush = 1'b0;
        bus.if_req   = 1'b0;
      end
      if (c == 5) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL flush_busy got %b want 1", bus.busy);
        end
      end
      if (c == 3) bus.if_flush = 1'b1;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL flush_done got %0d want 0", dcnt);
    end
  endtask

  task automatic test_pause_store();
    wr_t o;
    wr_t e;
    int lat;
    @(negedge clk);
    q_obs.delete();
    q_exp.push_back({32'h40, 8'hD4});
    q_exp.push_back({32'h41, 8'hC3});
    q_exp.push_back({32'h42, 8'hB2});
    q_exp.push_back({32'h43, 8'hA1});
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_size  = 2'b11;
    bus.mem_addr  = 32'h40;
    bus.mem_wdata = 32'hA1B2_C3D4;
    lat = 0;
    for (int c = 1; c <= 15 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 3 || c == 4) begin
        checks++;
        if (bus.ram_wr !== 1'b0 || bus.ram_a !== 32'h41) begin
          errors++;
          $display("FAIL pause_hold%0d got %b/%h want 0/41",
                   c, bus.ram_wr, bus.ram_a);
        end
      end
      if (c == 2) bus.rdy_in = 1'b0;
      if (c == 4) bus.rdy_in = 1'b1;
      if (bus.mem_done) begin
        lat = c;
        bus.mem_req = 1'b0;
      end
    end
    bus.rdy_in  = 1'b1;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL pause_lat got %0d want 7", lat);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_obs.size() == 0) begin
        errors++;
        $display("FAIL pause_write got none want %h/%h", e.a, e.d);
      end else begin
        o = q_obs.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL pause_write got %h/%h want %h/%h",
                   o.a, o.d, e.a, e.d);
        end
      end
    end
    checks++;
    if (q_obs.size() != 0) begin
      errors++;
      $display("FAIL pause_extra got %0d want 0", q_obs.size());
    end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    @(negedge clk);
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_size = 2'b11;
    bus.mem_addr = 32'h200;
    dcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.mem_done) dcnt++;
      if (c == 4) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.ram_a !== 32'd0) begin
          errors++;
          $display("FAIL rmid_out got %b/%h want 0/0",
                   bus.busy, bus.ram_a);
        end
        rst = 1'b0;
        bus.mem_req = 1'b0;
      end
      if (c == 3) rst = 1'b1;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL rmid_done got %0d want 0", dcnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g1;
    logic [31:0] g2;
    logic [31:0] exp;
    int d1;
    int d2;
    q_mem.push_back(32'h0000_0013);
    q_mem.push_back(32'h0000_0013);
    @(negedge clk);
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_size = 2'b00;
    bus.mem_addr = 32'h100;
    d1 = 0;
    d2 = 0;
    g1 = 32'd0;
    g2 = 32'd0;
    for (int c = 1; c <= 20 && d2 == 0; c++) begin
      @(negedge clk);
      if (bus.mem_done) begin
        if (d1 == 0) begin
          d1 = c;
          g1 = bus.mem_rdata;
        end else begin
          d2 = c;
          g2 = bus.mem_rdata;
          bus.mem_req = 1'b0;
        end
      end
    end
    bus.mem_req = 1'b0;
    checks++;
    if (d1 != 3 || d2 != 7) begin
      errors++;
      $display("FAIL b2b_spacing got %0d/%0d want 3/7", d1, d2);
    end
    exp = q_mem.pop_front();
    checks++;
    if (g1 !== exp) begin
      errors++;
      $display("FAIL b2b_data1 got %h want %h", g1, exp);
    end
    exp = q_mem.pop_front();
    checks++;
    if (g2 !== exp) begin
      errors++;
      $display("FAIL b2b_data2 got %h want %h", g2, exp);
    end
  endtask

  task automatic test_fairness();
    logic [31:0] id;
    int mcnt;
    int at;
    int want;
    bit seen;
`ifdef ARB_FAIRNESS_EN
    want = 4;
`else
    want = 5;
`endif
    @(negedge clk);
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h100;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_size = 2'b01;
    bus.mem_addr = 32'h100;
    mcnt = 0;
    at   = -1;
    seen = 1'b0;
    id   = 32'd0;
    for (int c = 1; c <= 80 && !(seen && mcnt >= 5); c++) begin
      @(negedge clk);
      if (bus.mem_done) mcnt++;
      if (bus.if_done) begin
        seen = 1'b1;
        at   = mcnt;
        id   = bus.if_data;
        bus.if_req = 1'b0;
      end
      if (mcnt >= 5) bus.mem_req = 1'b0;
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    checks++;
    if (at != want) begin
      errors++;
      $display("FAIL fair_order got %0d want %0d", at, want);
    end
    checks++;
    if (id !== 32'h0050_0013) begin
      errors++;
      $display("FAIL fair_idata got %h want 00500013", id);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.rdy_in    = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.if_flush  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_size  = 2'b00;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    test_reset();
    test_if_fetch();
    test_priority();
    test_store_half();
    test_io_load();
    test_flush();
    test_pause_store();
    test_reset_mid();
    test_back_to_back();
    test_fairness();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide RAM/IO port of the RV32I core between the instruction-fetch requester (IF) and the load/store requester (MEM). Each granted request is sequenced as 1, 2 or 4 byte beats, with results reassembled into 32-bit words. The block sits between the IF/MEM stages and the top-level memory pins. It honours the global `rdy_in` pause and IO-region single-byte semantics.

## Interface
- `STARVE_LIMIT`, default 4: consecutive MEM grants while IF waits before IF is forced (fairness build only).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global run enable; 0 freezes the block.
- `if_req` in 1: fetch request; level, held until `if_done` or flush.
- `if_addr` in 32: fetch address; stable while `if_req`.
- `if_flush` in 1: cancel outstanding fetch (branch/jump).
- `if_done` out 1: one-cycle pulse; `if_data` valid.
- `if_data` out 32: fetched instruction, little-endian.
- `mem_req` in 1: load/store request; level, held until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_size` in 2: 01 byte, 10 half, 11 word; 00 is illegal and treated as 01.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data; low bytes used.
- `mem_done` out 1: one-cycle pulse; store complete or `mem_rdata` valid.
- `mem_rdata` out 32: load data, zero-extended. The load unit sign-extends.
- `ram_a` out 32: RAM/IO address.
- `ram_dout` out 8: write byte.
- `ram_wr` out 1: 1 = write beat.
- `ram_din` in 8: read byte. Valid one cycle after its address is driven.
- `busy` out 1: transaction in progress (state ≠ IDLE).

## Operation
- The state machine has four states:
  - IDLE: arbitrate.
  - RD: issue read addresses and capture bytes.
  - WR: drive write bytes.
  - DONE: pulse the done output; no grant here.
- Arbitration in IDLE:
  - MEM wins over IF when both are requesting.
  - IF wins when only `if_req` is asserted and `if_flush`=0.
  - The winner's addr, size, we and wdata are latched at grant.
- Beat count n:
  - IF: 4.
  - MEM: 1, 2 or 4 from `mem_size`.
  - IO region (`mem_addr[17:16]`==2'b11): n=1 for loads regardless of size. Stores obey size.
- RD: byte k is addressed at `addr+k`, for k = 0..n-1, one per cycle. The `ram_din` byte for beat k is written to bits [8k+7:8k]. Unread bytes are 0.
- WR: `ram_wr`=1, `ram_a`=`addr+k`, `ram_dout`=`wdata[8k+7:8k]`, one byte per cycle.
- DONE: pulse `if_done` or `mem_done` for exactly one cycle with the assembled data, then go to IDLE. Data outputs are 0 when not done.
- Flush:
  - `if_flush` during an IF read, or in the grant cycle, lets the bus sequence finish but suppresses `if_done`.
  - `if_flush` in IDLE blocks an IF grant that cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- `rdy_in`=0:
  - All registers hold.
  - `ram_wr` is forced to 0 combinationally.
  - The RAM is also frozen, so `ram_din` stays valid.
  - The interrupted beat is re-driven when `rdy_in` returns.
- `rst` mid-transaction:
  - The transaction is abandoned and no done pulse is produced.
  - All outputs go to 0 and the state returns to IDLE in the next cycle.

## Timing
- All outputs are registered. The one exception is `ram_wr` gating by `rdy_in`.
- Reset values: all outputs 0; `busy`=0; state IDLE; starvation counter 0.
- Read with grant edge at end of cycle T:
  - `ram_a` is driven in cycles T+1..T+n.
  - Bytes are captured in cycles T+2..T+n+1.
  - Done pulses in cycle T+n+2. This gives a word latency of 6 cycles from request to done.
- Write with grant at T:
  - Bytes are driven in cycles T+1..T+n.
  - Done pulses in cycle T+n+1.
- Requesters see done and drop `req` in the next cycle. The DONE state guarantees that a stale `req` is never re-granted.
- Back-to-back transactions have a minimum spacing of one DONE cycle plus one IDLE cycle.
- Each `rdy_in`=0 cycle adds one cycle to every latency above.

## Configuration
- `ARB_FAIRNESS_EN` defined:
  - A counter increments on each MEM grant made while `if_req` is high.
  - The counter clears on any IF grant.
  - When the counter reaches `STARVE_LIMIT`, the next arbitration goes to IF even if `mem_req`=1.
- Undefined: strict MEM priority; no counter logic.

## Test plan
- IF word fetch, `if_addr`=0x100, RAM bytes 13,00,50,00:
  - `ram_a` steps 0x100..0x103.
  - `if_done` pulses in cycle T+6 with `if_data`=0x00500013.
- Simultaneous `if_req` and `mem_req` (load word 0x200): MEM is granted first; IF completes after MEM's DONE and IDLE cycles.
- Store half 0xBEEF to 0x31: `ram_wr`=1 for two cycles, (0x31, EF) then (0x32, BE); `mem_done` pulses at T+3.
- IO load word at 0x30000, `ram_din`=0x41: one read beat; `mem_rdata`=0x00000041.
- `if_flush` during the third fetch beat: the bus finishes its 4 beats and no `if_done` is produced; `rdy_in`=0 for 2 cycles mid-store re-drives the same byte with `ram_wr` low while paused.
- With `ARB_FAIRNESS_EN`, `STARVE_LIMIT`=4, `mem_req` held continuously: IF is granted after the 4th MEM transaction.
